// File: rtl/qam_sym_mapper.sv
// qam_sym_mapper: serial-bit to I/Q symbol mapper.
// Collects 2k bits per symbol (k=1/2/3 for QPSK/16-QAM/64-QAM), Gray-decodes
// each axis and emits signed odd-integer levels 2n-(2^k-1).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bit_in/bit_valid    serial input bit and its valid
//   bit_ready           input accepted this cycle
//   mode                0=QPSK, 1=16-QAM, 2=64-QAM, 3=16-QAM
//   flush               discard the partially collected symbol
//   sym_i, sym_q        signed I/Q levels (LEVEL_W)
//   sym_raw             collected bits, right-aligned, first bit MSB
//   sym_k               bits per axis of the held symbol
//   sym_valid/sym_ready output handshake
//   sym_count           delivered symbols, wrapping
module qam_sym_mapper #(
    parameter int MAX_K   = 3,
    parameter int LEVEL_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic [1:0]           mode,
    input  logic                 flush,
    output logic [LEVEL_W-1:0]   sym_i,
    output logic [LEVEL_W-1:0]   sym_q,
    output logic [2*MAX_K-1:0]   sym_raw,
    output logic [1:0]           sym_k,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [CNT_W-1:0]     sym_count
);
    localparam int RW = 2 * MAX_K;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    logic [RW-1:0]      shreg;
    logic [CW-1:0]      bit_cnt;
    logic [1:0]         k_lat;
    logic               rdy_en;

    logic [1:0]         k_mode;
    logic               completing;
    logic               accept;
    logic               load;
    logic               handshake;
    logic [RW-1:0]      raw_full;
    logic [RW-1:0]      i_sh;
    logic [MAX_K-1:0]   i_g;
    logic [MAX_K-1:0]   q_g;

    // Gray field (right-aligned, zeros above k) to signed level.
    // Zero upper bits leave the prefix-XOR of the live bits unchanged.
    function automatic logic [LEVEL_W-1:0] axis_level(input logic [MAX_K-1:0] g,
                                                       input logic [1:0] k);
        logic [MAX_K-1:0]   n;
        logic [LEVEL_W-1:0] mag;
        logic [LEVEL_W-1:0] off;
        n[MAX_K-1] = g[MAX_K-1];
        for (int j = MAX_K - 2; j >= 0; j--) n[j] = n[j+1] ^ g[j];
        mag          = '0;
        mag[MAX_K:1] = n;
        off          = (LEVEL_W'(1) << k) - LEVEL_W'(1);
        return mag - off;
    endfunction

    // Unsupported modes fall back to 16-QAM, or QPSK if 16-QAM is absent.
    always_comb begin
        k_mode = 2'd2;
        case (mode)
            2'd0:    k_mode = 2'd1;
            2'd2:    k_mode = 2'd3;
            default: k_mode = 2'd2;
        endcase
        if (k_mode > 2'(MAX_K)) k_mode = (MAX_K >= 2) ? 2'd2 : 2'd1;
    end

    // The final bit index is never 0, so k_lat is always valid here.
    assign completing = (bit_cnt != '0) && (bit_cnt == CW'({k_lat, 1'b0} - 3'd1));
    assign bit_ready  = rdy_en && !flush && !(completing && sym_valid && !sym_ready);
    assign accept     = bit_valid && bit_ready;
    assign load       = accept && completing;
    assign handshake  = sym_valid && sym_ready;

    // Field split and decode of the symbol completed by this bit.
    always_comb begin
        raw_full = {shreg[RW-2:0], bit_in};
        i_sh     = raw_full >> k_lat;
        i_g      = '0;
        q_g      = '0;
        for (int j = 0; j < MAX_K; j++) begin
            if (j < int'(k_lat)) begin
                i_g[j] = i_sh[j];
                q_g[j] = raw_full[j];
            end
        end
    end

    // Holds bit_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Collection side; shreg is cleared between symbols so sym_raw
    // comes out right-aligned with zeros above the 2k live bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            k_lat   <= '0;
        end else if (flush) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            if (bit_cnt == '0) k_lat <= k_mode;
            if (completing) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg   <= raw_full;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    // Output register: a new symbol overrides a same-cycle handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
            sym_raw   <= '0;
            sym_k     <= '0;
        end else if (load) begin
            sym_valid <= 1'b1;
            sym_i     <= axis_level(i_g, k_lat);
            sym_q     <= axis_level(q_g, k_lat);
            sym_raw   <= raw_full;
            sym_k     <= k_lat;
        end else if (handshake) begin
            sym_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         sym_count <= '0;
        else if (handshake) sym_count <= sym_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_qam_sym_mapper.sv
// tb_qam_sym_mapper: directed bench for qam_sym_mapper with a scoreboard of
// expected symbols, popped and compared at each output handoff.
module tb_qam_sym_mapper;
    localparam int MAX_K   = 3;
    localparam int LEVEL_W = 8;
    localparam int CNT_W   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                bit_in = 1'b0;
    logic                bit_valid = 1'b0;
    logic                bit_ready;
    logic [1:0]          mode = 2'd1;
    logic                flush = 1'b0;
    logic [LEVEL_W-1:0]  sym_i;
    logic [LEVEL_W-1:0]  sym_q;
    logic [2*MAX_K-1:0]  sym_raw;
    logic [1:0]          sym_k;
    logic                sym_valid;
    logic                sym_ready = 1'b0;
    logic [CNT_W-1:0]    sym_count;

    typedef struct {
        logic [LEVEL_W-1:0] i;
        logic [LEVEL_W-1:0] q;
        logic [5:0]         raw;
        logic [1:0]         k;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   delivered = 0;

    qam_sym_mapper #(.MAX_K(MAX_K), .LEVEL_W(LEVEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .mode(mode), .flush(flush), .sym_i(sym_i),
        .sym_q(sym_q), .sym_raw(sym_raw), .sym_k(sym_k), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference level: binary from 3-bit Gray, then 2n-(2^k-1).
    function automatic logic [LEVEL_W-1:0] ref_level(input int g, input int k);
        int n;
        n = g ^ (g >> 1) ^ (g >> 2);
        return LEVEL_W'(2 * n - ((1 << k) - 1));
    endfunction

    task automatic push_exp(input int k, input logic [5:0] val);
        exp_t e;
        int   v;
        v     = int'(val);
        e.i   = ref_level(v >> k, k);
        e.q   = ref_level(v & ((1 << k) - 1), k);
        e.raw = val;
        e.k   = 2'(k);
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        int n;
        bit_valid = 1'b1;
        bit_in    = b;
        n         = 0;
        forever begin
            @(negedge clk);
            if (bit_ready) break;
            n++;
            if (n > 200) begin
                chk("bit_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input int nb, input logic [5:0] val);
        for (int b = nb - 1; b >= 0; b--) send_bit(val[b]);
    endtask

    task automatic send_sym(input int k, input logic [5:0] val);
        push_exp(k, val);
        send_bits(2 * k, val);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each negedge with valid&ready precedes exactly one handoff edge.
    always @(negedge clk) begin
        if (rst_n && sym_valid && sym_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_symbol", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sym_i", 32'(sym_i), 32'(e.i));
                chk("sym_q", 32'(sym_q), 32'(e.q));
                chk("sym_raw", 32'(sym_raw), 32'(e.raw));
                chk("sym_k", 32'(sym_k), 32'(e.k));
                chk("sym_count", 32'(sym_count), 32'(delivered % 16));
            end
            delivered++;
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_valid", 32'(sym_valid), 32'd0);
        chk("rst_i", 32'(sym_i), 32'd0);
        chk("rst_raw", 32'(sym_raw), 32'd0);
        chk("rst_count", 32'(sym_count), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("ready_after_rst", 32'(bit_ready), 32'd1);

        // 16-QAM, QPSK, 64-QAM mapping with free-flowing output
        sym_ready = 1'b1;
        mode = 2'd1;
        send_sym(2, 6'b001011);
        chk("latency_valid", 32'(sym_valid), 32'd1);
        chk("qam16_i", 32'(sym_i), 32'h03);
        chk("qam16_q", 32'(sym_q), 32'h01);
        mode = 2'd0;
        send_sym(1, 6'b000001);
        chk("qpsk_i", 32'(sym_i), 32'hFF);
        mode = 2'd2;
        send_sym(3, 6'b100000);
        chk("qam64_q", 32'(sym_q), 32'hF9);
        mode = 2'd3;
        send_sym(2, 6'b001110);
        idle(3);
        chk("count_after_4", 32'(sym_count), 32'd4);

        // Backpressure: first symbol held, final bit of second stalls
        sym_ready = 1'b0;
        mode = 2'd1;
        send_sym(2, 6'b001011);
        push_exp(2, 6'b000100);
        send_bits(3, 6'b000010);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_bit_ready", 32'(bit_ready), 32'd0);
            chk("bp_hold_i", 32'(sym_i), 32'h03);
            chk("bp_hold_raw", 32'(sym_raw), 32'b1011);
        end
        @(posedge clk);
        #1;
        sym_ready = 1'b1;
        send_bit(1'b0);
        chk("bp_second_valid", 32'(sym_valid), 32'd1);
        idle(2);

        // Mode change mid-symbol: 16-QAM completes, next is 64-QAM
        mode = 2'd1;
        push_exp(2, 6'b000110);
        send_bits(2, 6'b000001);
        mode = 2'd2;
        send_bits(2, 6'b000010);
        send_sym(3, 6'b011010);
        chk("mode_chg_k", 32'(sym_k), 32'd3);
        idle(2);

        // Flush after 3 bits, then a fresh symbol
        mode = 2'd1;
        send_bits(3, 6'b000111);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_bit_ready", 32'(bit_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        send_sym(2, 6'b000000);
        chk("flush_i", 32'(sym_i), 32'hFD);
        chk("flush_q", 32'(sym_q), 32'hFD);
        idle(2);

        // Flush coincident with the final bit: no symbol
        send_bits(3, 6'b000101);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        bit_valid = 1'b0;
        idle(2);
        chk("flush_final_valid", 32'(sym_valid), 32'd0);
        chk("flush_final_sb", 32'(exp_q.size()), 32'd0);
        send_sym(2, 6'b001001);
        idle(2);

        // Reset mid-symbol with a symbol held
        sym_ready = 1'b0;
        send_sym(2, 6'b000111);
        send_bits(2, 6'b000010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(sym_valid), 32'd0);
        chk("midrst_i", 32'(sym_i), 32'd0);
        chk("midrst_q", 32'(sym_q), 32'd0);
        chk("midrst_k", 32'(sym_k), 32'd0);
        chk("midrst_count", 32'(sym_count), 32'd0);
        chk("midrst_bit_ready", 32'(bit_ready), 32'd0);
        exp_q.delete();
        delivered = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk("midrst_ready_back", 32'(bit_ready), 32'd1);

        // Counter wrap: 17 back-to-back QPSK symbols
        sym_ready = 1'b1;
        mode = 2'd0;
        for (int s = 0; s < 17; s++) send_sym(1, 6'(s & 3));
        idle(3);
        chk("wrap_count", 32'(sym_count), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/qam_sym_mapper.md
# qam_sym_mapper

Parametrised serial-bit to I/Q symbol mapper for the modulation path, sitting between the bit source and the carrier multiplier stage. It collects 2, 4 or 6 bits per symbol (QPSK / 16-QAM / 64-QAM, selectable at run time), Gray-decodes each axis and emits signed odd-integer I/Q amplitude levels. Both sides use valid/ready handshakes with backpressure.

## Interface
- `MAX_K`, default 3: maximum bits per axis; 3 enables 64-QAM. Legal values are 1–3.
- `LEVEL_W`, default 8: width of the signed output levels. Must be ≥ MAX_K+1.
- `CNT_W`, default 16: width of the symbol counter.
- `clk`  in  1: sole clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `bit_in`  in  1: serial data bit.
- `bit_valid`  in  1: `bit_in` is presented.
- `bit_ready`  out  1: the mapper accepts `bit_in` this cycle.
- `mode`  in  2: modulation select. 0 = QPSK (k=1), 1 = 16-QAM (k=2), 2 = 64-QAM (k=3), 3 = reserved, treated as 16-QAM. Any mode with k > MAX_K is also treated as 16-QAM; if MAX_K=1, it is treated as QPSK.
- `flush`  in  1: synchronous discard of a partially collected symbol.
- `sym_i`  out  LEVEL_W: signed I level.
- `sym_q`  out  LEVEL_W: signed Q level.
- `sym_raw`  out  2*MAX_K: collected bits, right-aligned, first bit most significant.
- `sym_k`  out  2: the k used for the current output symbol.
- `sym_valid`  out  1: an output symbol is held.
- `sym_ready`  in  1: the consumer takes the symbol.
- `sym_count`  out  CNT_W: number of symbols delivered (valid and ready both high), wrapping.

## Operation
- **Bit acceptance.** A bit is accepted when `bit_valid` and `bit_ready` are both high. Accepted bits shift into `shreg`, and `bit_cnt` increments.
- **Mode latch.** `mode` is sampled into `k_lat` only when the first bit of a symbol is accepted (`bit_cnt`=0). Changes to `mode` mid-symbol take effect at the next symbol.
- **Field split.** For a symbol with bits b0..b(2k−1) in arrival order:
  - the I field is b0..b(k−1), with b0 as MSB;
  - the Q field is bk..b(2k−1), with bk as MSB.
- **Gray decode.** Per field: n[MSB] = g[MSB]; n[j] = n[j+1] XOR g[j].
- **Level.** level = 2n − (2^k − 1), sign-extended to LEVEL_W.
  - QPSK gives ±1.
  - 16-QAM gives {−3, −1, 1, 3}.
  - 64-QAM gives the odd integers −7..7.
- **Symbol completion.** When the 2k-th bit is accepted:
  - the decoded symbol loads the output register, and `sym_valid` is set;
  - `bit_cnt` returns to 0.
- **Output hold.** `sym_valid` clears on a handshake unless a new symbol loads in the same cycle. Outputs are stable while `sym_valid`=1 and `sym_ready`=0.
- **Backpressure.** `bit_ready` = NOT(completing bit AND `sym_valid` AND NOT `sym_ready`). Non-final bits are always accepted; only the final bit of a symbol stalls.
- **Flush.**
  - `flush` clears `bit_cnt` and `shreg`, and any bit offered that cycle is dropped; `bit_ready` is 0 while `flush`=1.
  - The output register is untouched and may still hand off in the same cycle.
- **States.**
  - COLLECT covers `bit_cnt` 0..2k−1.
  - The output register (EMPTY/FULL) is tracked independently.
  - There is no other FSM state.
- **Counter.** `sym_count` increments on each handshake and wraps 2^CNT_W−1 → 0.

## Timing
- **Reset values.** On `rst_n`=0, asynchronously:
  - `sym_valid`=0;
  - `sym_i`, `sym_q`, `sym_raw`, `sym_k`, `sym_count`, `bit_cnt`, `shreg`, `k_lat` all 0;
  - `bit_ready`=0 while in reset, and 1 from the first clock after deassertion.
- **Latency.** Final bit accepted at edge t → `sym_valid`=1 with the new values after edge t (visible in cycle t+1).
- **Throughput.** One bit per cycle; one symbol per 2k cycles, sustained with `sym_ready`=1.
- **Simultaneous events.**
  - Final bit plus a handshake on the old symbol: the new symbol replaces it and `sym_valid` stays 1. There is no bubble.
  - `flush` plus the final bit: the flush wins and no symbol is produced.
- **Reset mid-symbol.** The partial symbol is lost and a held output is dropped.

## Test plan
- **16-QAM mapping.** `mode`=1, bits 1,0,1,1 with `sym_ready`=1 → one cycle after the 4th bit: `sym_i`=3, `sym_q`=1, `sym_raw`=1011 (bits [3:0] of the MAX_K=3 output), `sym_k`=2, `sym_count`=1.
- **QPSK and 64-QAM mapping.**
  - `mode`=0, bits 0,1 → `sym_i`=−1 (8'hFF), `sym_q`=+1.
  - `mode`=2, bits 1,0,0,0,0,0 → `sym_i`=7, `sym_q`=−7 (8'hF9).
- **Backpressure.** `sym_ready`=0, two full 16-QAM symbols offered →
  - the first is held stable;
  - `bit_ready`=0 on the 8th bit until `sym_ready`=1;
  - the second symbol appears the cycle after; no bit is lost or duplicated.
- **Mode change mid-symbol.** `mode` switches 1→2 after bit 2 → the current symbol completes after 4 bits as 16-QAM; the next symbol takes 6 bits, with `sym_k`=3.
- **Flush.**
  - Flush after 3 bits of a 16-QAM symbol, then bits 0,0,0,0 → output `sym_i`=−3, `sym_q`=−3.
  - Flush coincident with the final bit → no symbol produced.
- **Reset and wrap.** Assert `rst_n` mid-symbol with a symbol held → all outputs 0 immediately. With CNT_W=4, 17 symbols delivered → `sym_count`=1.
